// File: rtl/s2_link_peer.sv
// Far-end link peer: receives address+data frames into RB2 (updown=0) and serializes RB2
// words 0..WORDS-1 back onto sen/sd (updown=1). Define S2_PARITY_EN for an odd-parity bit.
module s2_link_peer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int WORDS  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              updown,
    output logic              S2_done,
    output logic              RB2_RW,
    output logic [ADDR_W-1:0] RB2_A,
    output logic [DATA_W-1:0] RB2_D,
    input  logic [DATA_W-1:0] RB2_Q,
    output logic              frame_err,
    inout  wire               sen,
    inout  wire               sd
);
    localparam int PAY_W = ADDR_W + DATA_W;
`ifdef S2_PARITY_EN
    localparam int FRAME_LEN = PAY_W + 1;
`else
    localparam int FRAME_LEN = PAY_W;
`endif
    localparam int CNT_W = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(FRAME_LEN + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WORDS - 1);

    typedef enum logic [1:0] {R_IDLE, R_SHIFT, R_WRITE} rx_state_t;
    typedef enum logic [2:0] {T_IDLE, T_LOAD, T_SHIFT, T_GAP, T_DONE} tx_state_t;

    rx_state_t            r_state_q, r_state_d;
    logic [CNT_W-1:0]     r_cnt_q, r_cnt_d;
    logic [FRAME_LEN-1:0] rx_sh_q, rx_sh_d;
    logic                 err_q, err_d;

    tx_state_t            t_state_q, t_state_d;
    logic [CNT_W-1:0]     t_cnt_q, t_cnt_d;
    logic [FRAME_LEN-1:0] tx_sh_q, tx_sh_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 sen_q, sen_d, sd_q, sd_d, done_q, done_d;

    logic [FRAME_LEN-1:0] rx_shift_in;
    logic [FRAME_LEN-1:0] tx_frame;
    logic                 rx_ok;
    logic                 wr_en;

    assign rx_shift_in = {rx_sh_q[FRAME_LEN-2:0], sd};

`ifdef S2_PARITY_EN
    assign rx_ok    = (r_cnt_q == CNT_FULL) && (^rx_sh_q);
    assign tx_frame = {addr_q, RB2_Q, ~^{addr_q, RB2_Q}};
`else
    assign rx_ok    = (r_cnt_q == CNT_FULL);
    assign tx_frame = {addr_q, RB2_Q};
`endif

    // The write strobe is suppressed on a reset cycle or once the link has turned around.
    assign wr_en     = (r_state_q == R_WRITE) && !updown && !rst;
    assign RB2_RW    = ~wr_en;
    assign RB2_A     = (r_state_q == R_WRITE) ? rx_sh_q[FRAME_LEN-1 -: ADDR_W] : addr_q;
    assign RB2_D     = rx_sh_q[FRAME_LEN-1-ADDR_W -: DATA_W];
    assign frame_err = err_q;
    assign S2_done   = done_q & updown;

    assign sen = updown ? sen_q : 1'bz;
    assign sd  = updown ? sd_q  : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            rx_sh_q   <= '0;
            err_q     <= 1'b0;
            t_state_q <= T_IDLE;
            t_cnt_q   <= '0;
            tx_sh_q   <= '0;
            addr_q    <= '0;
            sen_q     <= 1'b1;
            sd_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            rx_sh_q   <= rx_sh_d;
            err_q     <= err_d;
            t_state_q <= t_state_d;
            t_cnt_q   <= t_cnt_d;
            tx_sh_q   <= tx_sh_d;
            addr_q    <= addr_d;
            sen_q     <= sen_d;
            sd_q      <= sd_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        rx_sh_d   = rx_sh_q;
        err_d     = 1'b0;
        if (updown) begin
            r_state_d = R_IDLE;
            r_cnt_d   = '0;
        end else begin
            case (r_state_q)
                R_IDLE, R_WRITE: begin
                    r_state_d = R_IDLE;
                    if (!sen) begin
                        rx_sh_d   = rx_shift_in;
                        r_cnt_d   = CNT_W'(1);
                        r_state_d = R_SHIFT;
                    end
                end
                R_SHIFT: begin
                    if (!sen) begin
                        rx_sh_d = rx_shift_in;
                        // Saturate one past full so over-long frames stay distinguishable.
                        if (r_cnt_q != CNT_SAT) r_cnt_d = r_cnt_q + 1'b1;
                    end else begin
                        r_cnt_d = '0;
                        if (rx_ok) begin
                            r_state_d = R_WRITE;
                        end else begin
                            err_d     = 1'b1;
                            r_state_d = R_IDLE;
                        end
                    end
                end
                default: r_state_d = R_IDLE;
            endcase
        end
    end

    // sen_d/sd_d carry the line value for the state being entered.
    always_comb begin
        t_state_d = t_state_q;
        t_cnt_d   = t_cnt_q;
        tx_sh_d   = tx_sh_q;
        addr_d    = addr_q;
        sen_d     = 1'b1;
        sd_d      = 1'b0;
        done_d    = 1'b0;
        if (!updown) begin
            t_state_d = T_IDLE;
            t_cnt_d   = '0;
            addr_d    = '0;
        end else begin
            case (t_state_q)
                T_IDLE: begin
                    addr_d    = '0;
                    t_state_d = T_LOAD;
                end
                T_LOAD: begin
                    sen_d     = 1'b0;
                    sd_d      = tx_frame[FRAME_LEN-1];
                    tx_sh_d   = {tx_frame[FRAME_LEN-2:0], 1'b0};
                    t_cnt_d   = CNT_W'(1);
                    t_state_d = T_SHIFT;
                end
                T_SHIFT: begin
                    if (t_cnt_q == CNT_FULL) begin
                        t_state_d = T_GAP;
                    end else begin
                        sen_d   = 1'b0;
                        sd_d    = tx_sh_q[FRAME_LEN-1];
                        tx_sh_d = {tx_sh_q[FRAME_LEN-2:0], 1'b0};
                        t_cnt_d = t_cnt_q + 1'b1;
                    end
                end
                T_GAP: begin
                    if (addr_q == ADDR_LAST) begin
                        t_state_d = T_DONE;
                        done_d    = 1'b1;
                    end else begin
                        addr_d    = addr_q + 1'b1;
                        t_state_d = T_LOAD;
                    end
                end
                T_DONE:  done_d = 1'b1;
                default: t_state_d = T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_s2_link_peer.sv
// Bench for s2_link_peer: RX frames scored against a write queue, TX frames against a word queue.
module tb_s2_link_peer;
`ifdef S2_PARITY_EN
    localparam int FL = 14;
`else
    localparam int FL = 13;
`endif

    logic       clk = 1'b0;
    logic       rst, updown;
    logic       S2_done, RB2_RW, frame_err;
    logic [4:0] RB2_A;
    logic [7:0] RB2_D, RB2_Q;
    wire        sen, sd;
    logic       tb_oe, tb_sen, tb_sd;
    logic [7:0] mem [32];

    int errors = 0;
    int checks = 0;
    int err_cycles = 0;
    int tx_bits = 0, tx_hi = 0, tx_frames = 0, first_addr = -1;
    int cyc, reached;
    logic [12:0]   wr_q[$];
    logic [FL-1:0] tx_q[$];
    logic [12:0]   wr_e;
    logic [FL-1:0] tx_cap, tx_e;

    always #5 clk = ~clk;

    assign sen   = tb_oe ? tb_sen : 1'bz;
    assign sd    = tb_oe ? tb_sd  : 1'bz;
    assign RB2_Q = mem[RB2_A];

    s2_link_peer dut (
        .clk(clk), .rst(rst), .updown(updown), .S2_done(S2_done),
        .RB2_RW(RB2_RW), .RB2_A(RB2_A), .RB2_D(RB2_D), .RB2_Q(RB2_Q),
        .frame_err(frame_err), .sen(sen), .sd(sd)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [FL-1:0] mk(input logic [4:0] a, input logic [7:0] d);
`ifdef S2_PARITY_EN
        return {a, d, ~^{a, d}};
`else
        return {a, d};
`endif
    endfunction

    task automatic send(input logic [31:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            tb_sen = 1'b0;
            tb_sd  = v[i];
            @(posedge clk); #1;
        end
        tb_sen = 1'b1;
        tb_sd  = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send_good(input logic [4:0] a, input logic [7:0] d, input int gap);
        wr_q.push_back({a, d});
        send(32'(mk(a, d)), FL, gap);
    endtask

    task automatic wait_done(output int c);
        c = -1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (S2_done) begin c = i; break; end
        end
    endtask

    // RB2 write scoreboard and frame_err pulse counter
    always @(negedge clk) begin
        if (!rst && RB2_RW === 1'b0) begin
            if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
            else begin
                wr_e = wr_q.pop_front();
                check("wr_addr", RB2_A, wr_e[12:8]);
                check("wr_data", RB2_D, wr_e[7:0]);
            end
        end
        if (frame_err === 1'b1) err_cycles++;
    end

    // TX frame capture from the line
    always @(negedge clk) begin
        if (rst || !updown) begin
            tx_bits = 0; tx_hi = 0; tx_frames = 0;
        end else if (sen === 1'b0) begin
            if (tx_bits == 0 && tx_frames > 0) check("tx_gap", tx_hi, 2);
            tx_cap = {tx_cap[FL-2:0], sd};
            tx_bits++;
            tx_hi = 0;
        end else begin
            if (tx_bits != 0) begin
                check("tx_len", tx_bits, FL);
                if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else begin
                    tx_e = tx_q.pop_front();
                    check("tx_frame", tx_cap, tx_e);
                    if (tx_frames == 0) first_addr = tx_cap[FL-1 -: 5];
                    if (tx_e[FL-1 -: 5] == 5'd5) check("tx_word5", tx_cap[FL-1 -: 13], 13'b00101_10100000);
                end
                tx_frames++;
                tx_bits = 0;
            end
            tx_hi++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; updown = 1'b0; tb_oe = 1'b1; tb_sen = 1'b0; tb_sd = 1'b0;
        for (int k = 0; k < 32; k++) mem[k] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rw", RB2_RW, 1);
        check("rst_done", S2_done, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_addr", RB2_A, 0);
        check("rst_sen_released", sen, 0);
        tb_sen = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        send_good(5'd22, 8'hCA, 4);
        check("good_no_ferr", err_cycles, 0);
        send(32'h0ABC, FL - 1, 4);
        send(32'h1234, FL + 2, 4);
        check("ferr_cycles", err_cycles, 2);
        send_good(5'd3, 8'h5A, 4);
        send_good(5'd0, 8'h11, 1);
        send_good(5'd1, 8'h22, 4);
        send(32'h3F, 6, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("ferr_after_rst", err_cycles, 2);
        check("wr_pending", wr_q.size(), 0);

        for (int k = 0; k < 32; k++) begin
            mem[k] = 8'(k) ^ 8'hA5;
            tx_q.push_back(mk(5'(k), 8'(k) ^ 8'hA5));
        end
        tb_oe = 1'b0; updown = 1'b1;
        wait_done(cyc);
        check("done_cycle", cyc, 32 * (FL + 2));
        repeat (5) begin @(posedge clk); #1; end
        check("done_held", S2_done, 1);
        check("tx_pending", tx_q.size(), 0);
        updown = 1'b0; tb_oe = 1'b1; tb_sen = 1'b1; tb_sd = 1'b0;
        #1;
        check("done_clear", S2_done, 0);
        repeat (3) begin @(posedge clk); #1; end

        for (int k = 0; k < 32; k++) tx_q.push_back(mk(5'(k), 8'(k) ^ 8'hA5));
        tb_oe = 1'b0; updown = 1'b1;
        reached = 0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk); #1;
            if (tx_frames == 7 && tx_bits >= 4) begin reached = 1; break; end
        end
        check("abort_reach", reached, 1);
        updown = 1'b0; tb_oe = 1'b1; tb_sen = 1'b1; tb_sd = 1'b0;
        #1;
        check("abort_sen", sen, 1);
        check("abort_done", S2_done, 0);
        tx_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        check("abort_done_held", S2_done, 0);
        check("abort_ferr", err_cycles, 2);

        first_addr = -1;
        for (int k = 0; k < 32; k++) tx_q.push_back(mk(5'(k), 8'(k) ^ 8'hA5));
        tb_oe = 1'b0; updown = 1'b1;
        wait_done(cyc);
        check("restart_addr", first_addr, 0);
        check("done_cycle2", cyc, 32 * (FL + 2));
        check("tx_pending2", tx_q.size(), 0);
        updown = 1'b0; tb_oe = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
